// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - circular byte FIFO fed by the falling edge of the uartrx done line
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              done_q;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;

  logic wr_req;
  logic do_rd;
  logic do_wr;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    wr_req     = done_q & ~rx_done;
    do_rd      = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    do_wr      = wr_req & (~full | do_rd);
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;

    if (do_rd) begin
      rd_data_d  = mem_q[rp_q];
      rp_d       = rp_q + 1'b1;
      rd_valid_d = 1'b1;
    end
    if (do_wr) begin
      wp_d = wp_q + 1'b1;
    end

    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr_req && !do_wr) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q     <= rx_done;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is not reset; stale contents are never visible because count gates reads.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wp_q] <= rx_data;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] mq[$];
  logic [7:0] m_rd_data = 8'h00;
  logic       m_rd_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_prev_done = 1'b0;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
    .clr_ovf(clr_ovf), .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty),
    .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model applies the FIFO rules to the queue, then we sample after the edge.
  task automatic step(input logic done, input logic [7:0] d, input logic rd, input logic clr);
    int  n;
    logic ovf_set;
    @(negedge clk);
    rx_done = done; rx_data = d; rd_en = rd; clr_ovf = clr;
    n = mq.size();
    ovf_set = 1'b0;
    m_rd_valid = rd && (n > 0);
    if (m_rd_valid) m_rd_data = mq.pop_front();
    if (m_prev_done && !done) begin
      if (n < 16 || m_rd_valid) mq.push_back(d);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev_done = done;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rd);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, d, rd, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd_data = 8'h00; m_rd_valid = 1'b0; m_ovf = 1'b0; m_prev_done = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single_byte();
    send_byte(8'hBA, 1'b0);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_after_write got %0d exp 1", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty_after_write got %b exp 0", empty); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 8'hBA) begin errors++; $display("FAIL single_rd_data got %h exp ba", rd_data); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count_after_read got %0d exp 0", count); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_rd_valid_pulse got %b exp 0", rd_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_end got %b exp 1", empty); end
  endtask

  task automatic test_order_wrap();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full got %b exp 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got %b exp 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++; $display("FAIL wrap_read_a[%0d] got %h/%b exp %h/1", i, rd_data, rd_valid, 8'(i)); end
    end
    for (int i = 16; i < 24; i++) send_byte(8'(i), 1'b0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL wrap_count got %0d exp 16", count); end
    for (int i = 8; i < 24; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++; $display("FAIL wrap_read_b[%0d] got %h/%b exp %h/1", i, rd_data, rd_valid, 8'(i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    send_byte(8'hEE, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (rd_data !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL ovf_read[%0d] got %h exp %h", i, rd_data, 8'hA0 + 8'(i)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %b exp 1", empty); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    for (int i = 0; i < 16; i++) send_byte(8'h50 + 8'(i), 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, 8'h99, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL ovf_cleanup got ovf=%b empty=%b exp 0/1", overflow, empty); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) send_byte(8'h30 + 8'(i), 1'b0);
    send_byte(8'h77, 1'b1);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL simul_count got %0d exp 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %b exp 0", overflow); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h30) begin
      errors++; $display("FAIL simul_pop got %h/%b exp 30/1", rd_data, rd_valid); end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (rd_data !== ((i == 16) ? 8'h77 : 8'h30 + 8'(i))) begin
        errors++; $display("FAIL simul_read[%0d] got %h exp %h", i, rd_data, (i == 16) ? 8'h77 : 8'h30 + 8'(i)); end
    end
  endtask

  task automatic test_empty_read();
    logic [7:0] held;
    held = rd_data;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (rd_valid !== 1'b0 || rd_data !== m_rd_data) begin
      errors++; $display("FAIL empty_read got %h/%b exp %h/0", rd_data, rd_valid, m_rd_data); end
    send_byte(8'h5C, 1'b1);
    checks++; if (rd_valid !== 1'b0 || rd_data !== held) begin
      errors++; $display("FAIL empty_rd_wr got %h/%b exp %h/0", rd_data, rd_valid, held); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL empty_rd_wr_count got %0d exp 1", count); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (rd_data !== 8'h5C) begin errors++; $display("FAIL empty_followup got %h exp 5c", rd_data); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    send_byte(8'hC5, 1'b0);
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_precount got %0d exp 5", count); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
      errors++; $display("FAIL mid_reset_level got empty=%b count=%0d full=%b exp 1/0/0", empty, count, full); end
    checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs got %h/%b/%b exp 00/0/0", rd_data, rd_valid, overflow); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h6D, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h6D || empty !== 1'b1) begin
      errors++; $display("FAIL mid_fresh got %h/%b empty=%b exp 6d/1/1", rd_data, rd_valid, empty); end
  endtask

  task automatic test_random();
    logic d, r, c;
    for (int i = 0; i < 800; i++) begin
      d = 1'($urandom_range(0, 1));
      r = ((i / 100) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0);
      step(d, 8'($urandom), r, c);
      checks++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin
        errors++; $display("FAIL rand_read[%0d] got %h/%b exp %h/%b", i, rd_data, rd_valid, m_rd_data, m_rd_valid); end
      checks++; if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == 16)) begin
        errors++; $display("FAIL rand_level[%0d] got count=%0d e=%b f=%b exp count=%0d", i, count, empty, full, mq.size()); end
      checks++; if (overflow !== m_ovf) begin
        errors++; $display("FAIL rand_ovf[%0d] got %b exp %b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_order_wrap();
    test_overflow();
    test_simul_full();
    test_empty_read();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
